// File: rtl/pool_pkg.sv
// Shared types and helpers for the max-pooling reader.
package pool_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, WRITE} pool_state_t;

    function automatic int pool_out_dim(input int size, input int pool, input int stride);
        return (size - pool) / stride + 1;
    endfunction

endpackage

// File: rtl/pool_window_counter.sv
// Nested element (ki/kj) and window (wi/wj) counters for the pooling scan.
module pool_window_counter #(
    parameter int POOL = 2,
    parameter int OUT  = 2,
    localparam int KW  = (POOL > 1) ? $clog2(POOL) : 1,
    localparam int OW  = (OUT > 1) ? $clog2(OUT) : 1
) (
    input  logic          clock,
    input  logic          nreset,
    input  logic          clear,
    input  logic          step_elem,
    input  logic          step_win,
    output logic [KW-1:0] ki,
    output logic [KW-1:0] kj,
    output logic [OW-1:0] wi,
    output logic [OW-1:0] wj,
    output logic          last_elem,
    output logic          last_win
);

    localparam logic [KW-1:0] K_LAST = KW'(POOL - 1);
    localparam logic [OW-1:0] W_LAST = OW'(OUT - 1);

    assign last_elem = (ki == K_LAST) && (kj == K_LAST);
    assign last_win  = (wi == W_LAST) && (wj == W_LAST);

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            ki <= '0;
            kj <= '0;
            wi <= '0;
            wj <= '0;
        end else if (clear) begin
            ki <= '0;
            kj <= '0;
            wi <= '0;
            wj <= '0;
        end else begin
            // Each counter pair wraps to zero so the next window/run starts clean.
            if (step_elem) begin
                if (kj == K_LAST) begin
                    kj <= '0;
                    ki <= (ki == K_LAST) ? '0 : ki + 1'b1;
                end else begin
                    kj <= kj + 1'b1;
                end
            end
            if (step_win) begin
                if (wj == W_LAST) begin
                    wj <= '0;
                    wi <= (wi == W_LAST) ? '0 : wi + 1'b1;
                end else begin
                    wj <= wj + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/maxpool2d_reader.sv
// Snapshots a conv2D feature map on start's rising edge and max-pools it,
// one element compare per cycle, into a registered OUT x OUT map.
module maxpool2d_reader
    import pool_pkg::*;
#(
    parameter int SIZE      = 5,
    parameter int POOL      = 2,
    parameter int STRIDE    = 2,
    parameter int WIDTH_BIT = 8,
    localparam int OUT      = pool_out_dim(SIZE, POOL, STRIDE)
) (
    input  logic                                        clock,
    input  logic                                        nreset,
    input  logic                                        start,
    input  logic [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0]    featIn,
    output logic [OUT-1:0][OUT-1:0][WIDTH_BIT-1:0]      poolOut,
    output logic                                        busy,
    output logic                                        done
);

    localparam int KW = (POOL > 1) ? $clog2(POOL) : 1;
    localparam int OW = (OUT > 1) ? $clog2(OUT) : 1;
    localparam int RW = (SIZE > 1) ? $clog2(SIZE) : 1;

    pool_state_t                              state;
    logic                                     start_q;
    logic [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0] snap;
    logic signed [WIDTH_BIT-1:0]              acc;
    logic signed [WIDTH_BIT-1:0]              elem;
    logic [KW-1:0]                            ki, kj;
    logic [OW-1:0]                            wi, wj;
    logic [RW-1:0]                            row, col;
    logic                                     last_elem, last_win;
    logic                                     rise;

    assign rise = start & ~start_q;

    pool_window_counter #(
        .POOL(POOL),
        .OUT (OUT)
    ) u_cnt (
        .clock    (clock),
        .nreset   (nreset),
        .clear    ((state == IDLE) && rise),
        .step_elem(state == SCAN),
        .step_win (state == WRITE),
        .ki       (ki),
        .kj       (kj),
        .wi       (wi),
        .wj       (wj),
        .last_elem(last_elem),
        .last_win (last_win)
    );

    always_comb begin
        row  = RW'(int'(wi) * STRIDE + int'(ki));
        col  = RW'(int'(wj) * STRIDE + int'(kj));
        elem = snap[row][col];
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            start_q <= 1'b0;
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            acc     <= '0;
            snap    <= '0;
            poolOut <= '0;
        end else begin
            start_q <= start;
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (rise) begin
                        snap  <= featIn;
                        busy  <= 1'b1;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    // Strict greater-than: ties keep the earlier element.
                    if (ki == '0 && kj == '0)
                        acc <= elem;
                    else if (elem > acc)
                        acc <= elem;
                    if (last_elem)
                        state <= WRITE;
                end
                WRITE: begin
                    poolOut[wi][wj] <= acc;
                    if (last_win) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        state <= SCAN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool2d_reader.sv
// Randomized bench for maxpool2d_reader (default 5/2/2 and a 5/3/1 variant)
// against a plain-arithmetic max-pool reference.
module tb_maxpool2d_reader;

    logic clk = 1'b0;
    logic nreset;
    logic start_a, start_b;
    logic [4:0][4:0][7:0] feat_a, feat_b;
    logic [1:0][1:0][7:0] pool_a;
    logic [2:0][2:0][7:0] pool_b;
    logic busy_a, done_a, busy_b, done_b;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int dcnt_a = 0, dcyc_a = 0, dcnt_b = 0, dcyc_b = 0;
    int n;
    int fm[5][5];
    int expv[3][3];
    int exp_first[3][3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (done_a === 1'b1) begin dcnt_a++; dcyc_a = cyc; end
        if (done_b === 1'b1) begin dcnt_b++; dcyc_b = cyc; end
    end

    maxpool2d_reader #(.SIZE(5), .POOL(2), .STRIDE(2), .WIDTH_BIT(8)) dut_a (
        .clock(clk), .nreset(nreset), .start(start_a), .featIn(feat_a),
        .poolOut(pool_a), .busy(busy_a), .done(done_a)
    );

    maxpool2d_reader #(.SIZE(5), .POOL(3), .STRIDE(1), .WIDTH_BIT(8)) dut_b (
        .clock(clk), .nreset(nreset), .start(start_b), .featIn(feat_b),
        .poolOut(pool_b), .busy(busy_b), .done(done_b)
    );

    task automatic check(input string tag, input int got, input int want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: max over each POOL x POOL window, windows stepped by STRIDE.
    function automatic void ref_pool(input int p, input int st, input int od);
        for (int wi = 0; wi < od; wi++)
            for (int wj = 0; wj < od; wj++) begin
                int m;
                m = fm[wi*st][wj*st];
                for (int ki = 0; ki < p; ki++)
                    for (int kj = 0; kj < p; kj++)
                        if (fm[wi*st+ki][wj*st+kj] > m) m = fm[wi*st+ki][wj*st+kj];
                expv[wi][wj] = m;
            end
    endfunction

    function automatic void rand_fm();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                fm[r][c] = int'($urandom_range(0, 255)) - 128;
    endfunction

    function automatic logic [4:0][4:0][7:0] pack_fm();
        logic [4:0][4:0][7:0] v;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                v[r][c] = 8'(fm[r][c]);
        return v;
    endfunction

    task automatic check_pool_a(input string tag);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                check($sformatf("%s[%0d][%0d]", tag, i, j), int'($signed(pool_a[i][j])), expv[i][j]);
    endtask

    task automatic check_pool_b(input string tag);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                check($sformatf("%s[%0d][%0d]", tag, i, j), int'($signed(pool_b[i][j])), expv[i][j]);
    endtask

    task automatic pulse_a();
        start_a = 1'b1;
        tick();
        n = cyc;
        start_a = 1'b0;
    endtask

    // Waits for the next done on dut_a and checks when it arrived relative to n.
    task automatic wait_done_a(input string tag, input int lat);
        int d0;
        d0 = dcnt_a;
        for (int t = 0; t < lat + 10 && dcnt_a == d0; t++) tick();
        if (dcnt_a == d0) check({tag, "_timeout"}, 0, 1);
        else check({tag, "_lat"}, dcyc_a - n, lat);
    endtask

    task automatic run_a(input string tag);
        feat_a = pack_fm();
        ref_pool(2, 2, 2);
        pulse_a();
        wait_done_a(tag, 20);
        check_pool_a(tag);
    endtask

    task automatic run_b(input string tag);
        int d0;
        feat_b = pack_fm();
        ref_pool(3, 1, 3);
        d0 = dcnt_b;
        start_b = 1'b1;
        tick();
        n = cyc;
        start_b = 1'b0;
        for (int t = 0; t < 100 && dcnt_b == d0; t++) tick();
        if (dcnt_b == d0) check({tag, "_timeout"}, 0, 1);
        else check({tag, "_lat"}, dcyc_b - n, 90);
        check_pool_b(tag);
    endtask

    initial begin
        int d0;
        nreset = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        feat_a = '0;
        feat_b = '0;
        repeat (3) tick();
        check("rst_busy", int'(busy_a), 0);
        check("rst_done", int'(done_a), 0);
        check("rst_pool", int'(pool_a), 0);
        nreset = 1'b1;
        tick();

        // Ramp map with per-cycle busy/done timing.
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                fm[r][c] = r * 5 + c;
        feat_a = pack_fm();
        pulse_a();
        for (int t = 0; t <= 21; t++) begin
            check($sformatf("ramp_busy@%0d", t), int'(busy_a), (t < 20) ? 1 : 0);
            check($sformatf("ramp_done@%0d", t), int'(done_a), (t == 20) ? 1 : 0);
            if (t == 4) check("ramp_w0_before", int'($signed(pool_a[0][0])), 0);
            if (t == 5) check("ramp_w0_at5", int'($signed(pool_a[0][0])), 6);
            if (t < 21) tick();
        end
        check("ramp00", int'($signed(pool_a[0][0])), 6);
        check("ramp01", int'($signed(pool_a[0][1])), 8);
        check("ramp10", int'($signed(pool_a[1][0])), 16);
        check("ramp11", int'($signed(pool_a[1][1])), 18);

        // Signed window with ties in the -128 background.
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                fm[r][c] = -128;
        fm[0][0] = -5; fm[0][1] = -3; fm[1][0] = -7; fm[1][1] = -1;
        run_a("signed");
        check("signed00", int'($signed(pool_a[0][0])), -1);
        check("signed11", int'($signed(pool_a[1][1])), -128);

        // Held start: one run only, then drop and re-raise.
        rand_fm();
        feat_a = pack_fm();
        ref_pool(2, 2, 2);
        d0 = dcnt_a;
        start_a = 1'b1;
        repeat (60) tick();
        check("held_pulses", dcnt_a - d0, 1);
        check_pool_a("held");
        start_a = 1'b0;
        tick();
        rand_fm();
        run_a("reraise");

        // Rise while busy is ignored; results come from the first snapshot.
        rand_fm();
        feat_a = pack_fm();
        ref_pool(2, 2, 2);
        d0 = dcnt_a;
        pulse_a();
        while (cyc < n + 6) tick();
        rand_fm();
        feat_a = pack_fm();
        start_a = 1'b1;
        wait_done_a("busyign", 20);
        repeat (25) tick();
        check("busyign_pulses", dcnt_a - d0, 1);
        check_pool_a("busyign");
        start_a = 1'b0;
        tick();

        // Asynchronous reset mid-run.
        rand_fm();
        feat_a = pack_fm();
        pulse_a();
        while (cyc < n + 8) tick();
        #4 nreset = 1'b0;
        #1;
        check("mrst_busy", int'(busy_a), 0);
        check("mrst_done", int'(done_a), 0);
        check("mrst_pool", int'(pool_a), 0);
        repeat (2) tick();
        nreset = 1'b1;
        tick();
        rand_fm();
        run_a("after_rst");

        // Back-to-back: rise in the cycle after done.
        rand_fm();
        feat_a = pack_fm();
        ref_pool(2, 2, 2);
        pulse_a();
        while (cyc < n + 20) tick();
        check("b2b_done1", int'(done_a), 1);
        check_pool_a("b2b_first");
        rand_fm();
        feat_a = pack_fm();
        ref_pool(2, 2, 2);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_done_a("b2b_second", 41);
        check_pool_a("b2b_second");

        // Random maps on both configurations.
        for (int k = 0; k < 4; k++) begin
            rand_fm();
            run_a($sformatf("rnd%0d", k));
        end
        for (int k = 0; k < 2; k++) begin
            rand_fm();
            run_b($sformatf("p3s1_%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
